alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 126 ++++++++++++
 tb/tb_alu_issue_stage.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ALU issue stage: ID/EX register that drives an external ALU, and an EX/MEM
// register that captures the ALU result, store data, destination and branch outcome.
module alu_issue_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_alu_src,
    input  logic              id_branch,
    input  logic [4:0]        id_rd,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_in_a,
    output logic [DATA_W-1:0] alu_in_b,
    output logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              ex_mem_valid,
    output logic [DATA_W-1:0] ex_mem_result,
    output logic [DATA_W-1:0] ex_mem_rt_data,
    output logic [4:0]        ex_mem_rd,
    output logic              branch_taken
);

    // ID/EX state
    logic              idex_valid_q;
    logic [3:0]        idex_ctrl_q;
    logic [DATA_W-1:0] idex_a_q;
    logic [DATA_W-1:0] idex_b_q;
    logic [DATA_W-1:0] idex_rt_q;
    logic [4:0]        idex_rd_q;
    logic              idex_branch_q;

    // EX/MEM state
    logic              exm_valid_q;
    logic [DATA_W-1:0] exm_result_q;
    logic [DATA_W-1:0] exm_rt_q;
    logic [4:0]        exm_rd_q;
    logic              exm_branch_q;

    logic [3:0]        ctrl_d;
    logic [DATA_W-1:0] b_d;

    always_comb begin
        ctrl_d = 4'b1111;
        unique case (id_alu_op)
            2'b00: ctrl_d = 4'b0010;
            2'b01: ctrl_d = 4'b0110;
            2'b10: begin
                unique case (id_funct)
                    6'b100000: ctrl_d = 4'b0010;
                    6'b100010: ctrl_d = 4'b0110;
                    6'b100100: ctrl_d = 4'b0000;
                    6'b100101: ctrl_d = 4'b0001;
                    6'b101010: ctrl_d = 4'b0111;
                    default:   ctrl_d = 4'b1111;
                endcase
            end
            default: ctrl_d = 4'b1111;
        endcase
        b_d = id_alu_src ? id_imm : id_rt_data;
    end

    // Flush only kills the valid bit; the payload fields may go stale behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_valid_q  <= 1'b0;
            idex_ctrl_q   <= 4'b0000;
            idex_a_q      <= '0;
            idex_b_q      <= '0;
            idex_rt_q     <= '0;
            idex_rd_q     <= '0;
            idex_branch_q <= 1'b0;
        end else if (flush) begin
            idex_valid_q  <= 1'b0;
        end else if (!stall) begin
            idex_valid_q  <= id_valid;
            idex_ctrl_q   <= ctrl_d;
            idex_a_q      <= id_rs_data;
            idex_b_q      <= b_d;
            idex_rt_q     <= id_rt_data;
            idex_rd_q     <= id_rd;
            idex_branch_q <= id_branch;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exm_valid_q  <= 1'b0;
            exm_result_q <= '0;
            exm_rt_q     <= '0;
            exm_rd_q     <= '0;
            exm_branch_q <= 1'b0;
        end else if (!stall) begin
            if (idex_valid_q) begin
                exm_valid_q  <= 1'b1;
                exm_result_q <= alu_result;
                exm_rt_q     <= idex_rt_q;
                exm_rd_q     <= idex_rd_q;
                exm_branch_q <= idex_branch_q & alu_zero;
            end else begin
                exm_valid_q  <= 1'b0;
                exm_result_q <= '0;
                exm_rt_q     <= '0;
                exm_rd_q     <= '0;
                exm_branch_q <= 1'b0;
            end
        end
    end

    assign alu_in_a       = idex_a_q;
    assign alu_in_b       = idex_b_q;
    assign alu_control    = idex_ctrl_q;
    assign ex_mem_valid   = exm_valid_q;
    assign ex_mem_result  = exm_result_q;
    assign ex_mem_rt_data = exm_rt_q;
    assign ex_mem_rd      = exm_rd_q;
    assign branch_taken   = exm_branch_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; a behavioural ALU closes the loop between
// alu_in_*/alu_control and alu_result/alu_zero.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [1:0]  id_alu_op;
    logic [5:0]  id_funct;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic        id_alu_src, id_branch;
    logic [4:0]  id_rd;
    logic        stall, flush;
    logic [31:0] alu_in_a, alu_in_b, alu_result;
    logic [3:0]  alu_control;
    logic        alu_zero;
    logic        ex_mem_valid;
    logic [31:0] ex_mem_result, ex_mem_rt_data;
    logic [4:0]  ex_mem_rd;
    logic        branch_taken;

    int total = 0;
    int bad   = 0;

    alu_issue_stage #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_branch(id_branch), .id_rd(id_rd),
        .stall(stall), .flush(flush),
        .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .ex_mem_valid(ex_mem_valid), .ex_mem_result(ex_mem_result),
        .ex_mem_rt_data(ex_mem_rt_data), .ex_mem_rd(ex_mem_rd),
        .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = 32'h0;
        case (alu_control)
            4'b0010: alu_result = alu_in_a + alu_in_b;
            4'b0110: alu_result = alu_in_a - alu_in_b;
            4'b0000: alu_result = alu_in_a & alu_in_b;
            4'b0001: alu_result = alu_in_a | alu_in_b;
            4'b0111: alu_result = {31'h0, $signed(alu_in_a) < $signed(alu_in_b)};
            default: alu_result = alu_in_a;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic [1:0] op, input logic [5:0] fn, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm, input logic src,
                         input logic br, input logic [4:0] rd);
        id_valid = 1'b1; id_alu_op = op; id_funct = fn; id_rs_data = rs; id_rt_data = rt;
        id_imm = imm; id_alu_src = src; id_branch = br; id_rd = rd;
    endtask

    task automatic chk_exm(input string tag, input logic v, input logic [31:0] res,
                           input logic [31:0] rt, input logic [4:0] rd, input logic bt);
        chk({tag, "_valid"}, {31'h0, ex_mem_valid}, {31'h0, v});
        chk({tag, "_result"}, ex_mem_result, res);
        chk({tag, "_rt"}, ex_mem_rt_data, rt);
        chk({tag, "_rd"}, {27'h0, ex_mem_rd}, {27'h0, rd});
        chk({tag, "_br"}, {31'h0, branch_taken}, {31'h0, bt});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_alu_op = 2'b00; id_funct = 6'h0; id_rs_data = 32'h0;
        id_rt_data = 32'h0; id_imm = 32'h0; id_alu_src = 1'b0; id_branch = 1'b0; id_rd = 5'h0;
        tick(); tick();
        chk("rst_a", alu_in_a, 32'h0);
        chk("rst_b", alu_in_b, 32'h0);
        chk("rst_ctl", {28'h0, alu_control}, 32'h0);
        chk_exm("rst", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        reset = 1'b0;
        tick();
        chk("idle_valid", {31'h0, ex_mem_valid}, 32'h0);

        // R-type add 5+7
        instr(2'b10, 6'b100000, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, 5'd10);
        tick();
        chk("radd_ctl", {28'h0, alu_control}, 32'h2);
        chk("radd_a", alu_in_a, 32'd5);
        chk("radd_b", alu_in_b, 32'd7);
        id_valid = 1'b0;
        tick();
        chk_exm("radd", 1'b1, 32'd12, 32'd7, 5'd10, 1'b0);
        tick();
        chk_exm("radd_after", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);

        // beq taken
        instr(2'b01, 6'h0, 32'h1234, 32'h1234, 32'h0, 1'b0, 1'b1, 5'd0);
        tick();
        chk("beq_ctl", {28'h0, alu_control}, 32'h6);
        id_valid = 1'b0;
        tick();
        chk_exm("beq", 1'b1, 32'h0, 32'h1234, 5'd0, 1'b1);
        tick();
        chk("beq_bubble_br", {31'h0, branch_taken}, 32'h0);

        // beq not taken
        instr(2'b01, 6'h0, 32'd9, 32'd4, 32'h0, 1'b0, 1'b1, 5'd0);
        tick(); id_valid = 1'b0; tick();
        chk_exm("bne", 1'b1, 32'd5, 32'd4, 5'd0, 1'b0);

        // immediate add wraps
        instr(2'b00, 6'h0, 32'hFFFF_FFFF, 32'h55, 32'd1, 1'b1, 1'b0, 5'd2);
        tick();
        chk("imm_b", alu_in_b, 32'd1);
        id_valid = 1'b0;
        tick();
        chk_exm("imm", 1'b1, 32'h0, 32'h55, 5'd2, 1'b0);

        // slt, unknown funct, pass-A, and/or
        instr(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0, 5'd11);
        tick();
        chk("slt_ctl", {28'h0, alu_control}, 32'h7);
        instr(2'b10, 6'b000000, 32'hABCD, 32'd1, 32'h0, 1'b0, 1'b0, 5'd12);
        tick();
        chk("slt_res", ex_mem_result, 32'd1);
        chk("unk_ctl", {28'h0, alu_control}, 32'hF);
        instr(2'b10, 6'b100100, 32'hF0F0, 32'hFF00, 32'h0, 1'b0, 1'b0, 5'd13);
        tick();
        chk("unk_res", ex_mem_result, 32'hABCD);
        chk("and_ctl", {28'h0, alu_control}, 32'h0);
        instr(2'b10, 6'b100101, 32'hF0F0, 32'h0F00, 32'h0, 1'b0, 1'b0, 5'd14);
        tick();
        chk("and_res", ex_mem_result, 32'hF000);
        chk("or_ctl", {28'h0, alu_control}, 32'h1);
        instr(2'b11, 6'h0, 32'h77, 32'h1, 32'h0, 1'b0, 1'b0, 5'd15);
        tick();
        chk("or_res", ex_mem_result, 32'hFFF0);
        chk("pass_ctl", {28'h0, alu_control}, 32'hF);
        id_valid = 1'b0;
        tick();
        chk("pass_res", ex_mem_result, 32'h77);
        tick();

        // stall for three cycles with sub 20-3 in ID/EX, a new add waiting in ID
        instr(2'b01, 6'h0, 32'd20, 32'd3, 32'h0, 1'b0, 1'b0, 5'd9);
        tick();
        instr(2'b00, 6'h0, 32'd100, 32'h0, 32'd1, 1'b1, 1'b0, 5'd3);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_a", alu_in_a, 32'd20);
            chk("stall_b", alu_in_b, 32'd3);
            chk("stall_ctl", {28'h0, alu_control}, 32'h6);
            chk("stall_exv", {31'h0, ex_mem_valid}, 32'h0);
        end
        stall = 1'b0;
        tick();
        chk_exm("stall_done", 1'b1, 32'd17, 32'd3, 5'd9, 1'b0);
        chk("stall_next_a", alu_in_a, 32'd100);
        id_valid = 1'b0;
        tick();
        chk_exm("stall_next", 1'b1, 32'd101, 32'h0, 5'd3, 1'b0);
        tick();
        chk("stall_nodup", {31'h0, ex_mem_valid}, 32'h0);

        // flush with id_valid=1: prior entry completes, flushed one becomes bubble
        instr(2'b00, 6'h0, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 5'd4);
        tick();
        instr(2'b00, 6'h0, 32'd10, 32'd20, 32'h0, 1'b0, 1'b0, 5'd5);
        flush = 1'b1;
        tick();
        chk_exm("flush_prior", 1'b1, 32'd3, 32'd2, 5'd4, 1'b0);
        flush = 1'b0; id_valid = 1'b0;
        tick();
        chk_exm("flush_bubble", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);

        // flush + stall: EX/MEM holds, flushed entry never completes
        instr(2'b01, 6'h0, 32'd8, 32'd8, 32'h0, 1'b0, 1'b1, 5'd6);
        tick();
        id_valid = 1'b0; flush = 1'b1; stall = 1'b1;
        tick();
        chk("fs_hold_v", {31'h0, ex_mem_valid}, 32'h0);
        flush = 1'b0; stall = 1'b0;
        tick();
        chk_exm("fs_killed", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);

        // branch taken held through stall
        instr(2'b01, 6'h0, 32'd4, 32'd4, 32'h0, 1'b0, 1'b1, 5'd1);
        tick(); id_valid = 1'b0; tick();
        stall = 1'b1;
        tick(); tick();
        chk("br_hold", {31'h0, branch_taken}, 32'h1);
        stall = 1'b0;
        tick();
        chk("br_once", {31'h0, branch_taken}, 32'h0);

        // reset with two instructions in flight
        instr(2'b00, 6'h0, 32'd2, 32'd2, 32'h0, 1'b0, 1'b0, 5'd7);
        tick();
        instr(2'b00, 6'h0, 32'd3, 32'd3, 32'h0, 1'b0, 1'b0, 5'd8);
        tick();
        chk("pre_rst_res", ex_mem_result, 32'd4);
        instr(2'b00, 6'h0, 32'd6, 32'd6, 32'h0, 1'b0, 1'b0, 5'd9);
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        tick();
        chk("mrst_a", alu_in_a, 32'h0);
        chk("mrst_b", alu_in_b, 32'h0);
        chk("mrst_ctl", {28'h0, alu_control}, 32'h0);
        chk_exm("mrst", 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        reset = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mrst_nocomp", {31'h0, ex_mem_valid}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
